uart_frame_ctrl: RTL and testbench
==================================

# uart_frame_ctrl

Framing controller that sits downstream of the UART receiver. It turns the receiver's byte stream into validated register-write bursts. It watches the receiver's busy flag (`rx_int`) and data register (`rx_data`) and assembles frames of the form sync, address, length, payload and checksum. Payload is buffered, and only checksum-good frames are committed as a burst of single-cycle writes to the register file. Malformed, corrupt or stalled frames are discarded and reported.

## Interface
Parameters:
- MAX_LEN, 16: maximum payload bytes per frame (1..255).
- TIMEOUT, 250000: maximum clk cycles between byte strobes inside a frame (10 ms at 25 MHz).

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- rx_int  in  1  receiver busy flag; high while a byte is being received.
- rx_data  in  8  receiver data register; valid from the cycle rx_int falls.
- wr_en  out  1  register-write strobe, one cycle per payload byte.
- wr_addr  out  8  write address.
- wr_data  out  8  write data.
- frame_ok  out  1  one-cycle pulse on frame commit.
- frame_err  out  1  one-cycle pulse on frame discard.
- err_code  out  2  held until the next frame_err: 1 = checksum, 2 = length, 3 = timeout.
- busy  out  1  high in every state except IDLE.

## Operation
- Byte strobe: rx_int_d (registered rx_int, reset 0) is 1 and rx_int is 0. Data is rx_data sampled in that cycle. No strobe can occur out of reset.
- States and transitions, all taken on a strobe unless stated otherwise:
  - IDLE -> ADDR when the byte equals 8'h55. Other bytes are ignored silently.
  - ADDR -> LEN: latch base address; csum = byte.
  - LEN: byte = 0 or byte > MAX_LEN gives frame_err with code 2 and goes to IDLE. Otherwise latch len, idx = 0, csum ^= byte, and go to DATA.
  - DATA: write the byte to buf[idx], csum ^= byte, idx++. When idx reaches len, go to CSUM.
  - CSUM: byte == csum goes to BURST with idx = 0. Otherwise frame_err with code 1 and go to IDLE.
  - BURST, one write per cycle, no strobe needed: wr_en = 1, wr_addr = base + idx (mod 256, wraps FF->00), wr_data = buf[idx]. After the write with idx = len-1, go to IDLE.
- Checksum: 8-bit XOR of the address, length and all payload bytes. The sync byte is excluded.
- Timeout: a gap counter clears on every strobe and in IDLE, and counts in ADDR, LEN, DATA and CSUM. When it reaches TIMEOUT-1: frame_err with code 3, go to IDLE. A strobe in that same cycle wins: the counter clears and no timeout is raised.
- A strobe during BURST is dropped. A burst (at most 16 cycles) is always far shorter than one byte time, so this cannot occur at legal baud rates.
- Discarded frames produce no wr_en.
- Reset values: state IDLE; wr_en, frame_ok, frame_err and busy at 0; wr_addr, wr_data and err_code at 0; buffer contents undefined and unused.
- Reset asserted mid-frame or mid-burst aborts immediately with no further writes.

## Timing
- Strobe at cycle t on the last length byte with an error: frame_err pulses at t+1.
- Checksum strobe at cycle t:
  - Good: wr_en is high for cycles t+1..t+len, with consecutive addresses. frame_ok pulses together with the last wr_en at cycle t+len.
  - Bad: frame_err pulses at t+1.
- busy rises the cycle after the sync strobe and falls the cycle after the final wr_en or error pulse.
- All outputs are registered, with no combinational path from the inputs.

## Structure
- Shared package uart_pkg holds:
  - The SYNC_BYTE constant, 8'h55.
  - Error codes ERR_CSUM = 1, ERR_LEN = 2, ERR_TMO = 3.
  - The state encoding for IDLE, ADDR, LEN, DATA, CSUM and BURST.
- Sub-module uart_frame_buf: a MAX_LEN x 8 register file with one synchronous write port and one asynchronous read port indexed by idx.

## Test plan
- Good frame 55 10 02 A5 3C 8B -> writes (10,A5) then (11,3C) on consecutive cycles, frame_ok with the second write, no frame_err.
- Address wrap, 55 FF 02 01 02 FE -> writes (FF,01) then (00,02), frame_ok.
- Bad checksum, 55 10 02 A5 3C 8C -> frame_err with err_code 1, zero wr_en. A following good frame still commits.
- Length errors:
  - 55 10 00 -> frame_err with code 2 one cycle after the length strobe.
  - 55 10 11 with MAX_LEN 16 -> same response.
- Timeout: 55 10 02 A5, then silence -> frame_err with code 3 exactly TIMEOUT cycles after the A5 strobe, back to IDLE. The next byte, 3C, is ignored.
- Garbage and reset:
  - Bytes 00 FF AA in IDLE -> no outputs.
  - rst_n pulsed low during BURST of a len-8 frame -> wr_en falls at once, all outputs return to reset values, and the next frame decodes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART framing controller.
//   SYNC_BYTE        : start-of-frame marker
//   ERR_CSUM/LEN/TMO : err_code values reported with frame_err
//   state_e          : frame FSM state encoding
//   buf_aw()         : index width of a payload buffer of a given depth
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;

    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LEN   = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        BURST = 3'd5
    } state_e;

    // A depth-1 buffer still needs a 1-bit index.
    function automatic int buf_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// -----------------------------------------------------------------------------
// uart_frame_buf
// Payload buffer: MAX_LEN x 8 register file, one synchronous write port and
// one asynchronous read port. Contents have no reset; only bytes written in
// the current frame are ever read.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int MAX_LEN = 16,
    localparam int AW     = buf_aw(MAX_LEN)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_frame_ctrl
// Turns the UART receiver byte stream into validated register-write bursts.
// Frame: 55 | addr | len | payload[len] | csum, csum = XOR(addr, len, payload).
// Good frames are replayed as len single-cycle writes to addr, addr+1, ...
// Bad, oversize or stalled frames are dropped and reported on frame_err.
//
// Handshake: the receiver side is a strobe with no back-pressure (a byte is
// taken in the cycle rx_int falls); the write side is fire-and-forget, wr_en
// qualifies wr_addr/wr_data in the same cycle and there is no ready.
//
//   clk, rst_n     : clock, asynchronous active-low reset
//   rx_int/rx_data : receiver busy flag and data register
//   wr_en/addr/data: register-file write port
//   frame_ok/err   : one-cycle commit / discard pulses
//   err_code       : reason of the last discard, held
//   busy           : frame in progress
//   dbg_state      : current FSM state
// -----------------------------------------------------------------------------
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_int,
    input  logic [7:0] rx_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy,
    output state_e     dbg_state
);

    localparam int AW    = buf_aw(MAX_LEN);
    localparam int GAP_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Error is registered, so fire one count early: frame_err then lands in
    // the same cycle the counter would read TIMEOUT-1.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 2);

    state_e           state_q, state_d;
    logic             rx_int_q;
    logic [7:0]       base_q, base_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             busy_q, busy_d;

    logic             strobe;
    logic             counting;
    logic             tmo_hit;
    logic             buf_we;
    logic [AW-1:0]    buf_raddr;
    logic [7:0]       buf_rdata;

    assign strobe   = rx_int_q & ~rx_int;
    assign counting = (state_q == ADDR) || (state_q == LEN) ||
                      (state_q == DATA) || (state_q == CSUM);
    assign tmo_hit  = counting && !strobe && (gap_q == GAP_LAST);

    // In CSUM the first payload byte is fetched ahead of the burst; during
    // BURST idx_q always points at the next byte to emit.
    assign buf_we    = strobe && (state_q == DATA);
    assign buf_raddr = (state_q == BURST) ? idx_q[AW-1:0] : '0;

    uart_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (idx_q[AW-1:0]),
        .wdata_i (rx_data),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rx_int_q    <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            gap_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_int_q    <= rx_int;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            gap_q       <= gap_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        gap_d       = (counting && !strobe) ? gap_q + 1'b1 : '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        unique case (state_q)
            IDLE: begin
                if (strobe && rx_data == SYNC_BYTE) state_d = ADDR;
            end
            ADDR: begin
                if (strobe) begin
                    base_d  = rx_data;
                    csum_d  = rx_data;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (strobe) begin
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = IDLE;
                    end else begin
                        len_d   = rx_data;
                        idx_d   = '0;
                        csum_d  = csum_q ^ rx_data;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    csum_d = csum_q ^ rx_data;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q + 8'd1 == len_q) state_d = CSUM;
                end
            end
            CSUM: begin
                if (strobe) begin
                    if (rx_data == csum_q) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = base_q;
                        wr_data_d  = buf_rdata;
                        frame_ok_d = (len_q == 8'd1);
                        idx_d      = 8'd1;
                        state_d    = BURST;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        state_d     = IDLE;
                    end
                end
            end
            BURST: begin
                // Strobes are ignored here; the last write is already on the
                // output registers when idx_q reaches len_q.
                if (idx_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = base_q + idx_q;
                    wr_data_d  = buf_rdata;
                    frame_ok_d = (idx_q + 8'd1 == len_q);
                    idx_d      = idx_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tmo_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
            state_d     = IDLE;
        end

        // busy stays up through the cycle carrying the error pulse.
        busy_d = (state_d != IDLE) || frame_err_d;
    end

    // Outputs: all straight from registers
    always_comb begin
        wr_en     = wr_en_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        frame_ok  = frame_ok_q;
        frame_err = frame_err_q;
        err_code  = err_code_q;
        busy      = busy_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_ctrl
// Directed bench for uart_frame_ctrl with a short TIMEOUT. Bytes are delivered
// as receiver busy pulses; expected writes are queued as {addr, data}.
// -----------------------------------------------------------------------------
module tb_uart_frame_ctrl;
    import uart_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_int = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
    state_e     dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic [15:0] exp_q[$];

    uart_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_int    (rx_int),
        .rx_data   (rx_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #(40 * 40000);
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    // Returns inside the strobe cycle (rx_int just fell, rx_data valid).
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_int  = 1'b1;
        rx_data = 8'($urandom_range(0, 255));
        repeat (3) @(posedge clk);
        #1;
        rx_data = b;
        rx_int  = 1'b0;
    endtask

    // Called in the checksum strobe cycle of a good frame.
    task automatic check_burst(input int len, input string name);
        logic [15:0] exp;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            n_vec++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, exp}) begin
                n_err++;
                $display("FAIL %s write %0d: got en=%b %h/%h, required en=1 %h/%h",
                         name, i, wr_en, wr_addr, wr_data, exp[15:8], exp[7:0]);
            end
            n_vec++;
            if ({frame_ok, frame_err, busy} !== {(i == len - 1), 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL %s flags %0d: got ok/err/busy=%b%b%b, required %b01",
                         name, i, frame_ok, frame_err, busy, (i == len - 1));
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if ({wr_en, frame_ok, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL %s end: got en/ok/busy=%b%b%b, required 000",
                     name, wr_en, frame_ok, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++;
        if ({wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy} !== 22'd0 ||
            dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset: got en=%b a=%h d=%h ok=%b err=%b code=%0d busy=%b st=%0d, required all 0",
                     wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy, dbg_state);
        end
    endtask

    task automatic test_good_frame();
        send_byte(8'h55);
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_rise: got %b, required 1", busy);
        end
        send_byte(8'h10); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h3C);
        exp_q.push_back(16'h10A5);
        exp_q.push_back(16'h113C);
        send_byte(8'h8B);
        check_burst(2, "good");
    endtask

    task automatic test_addr_wrap();
        send_byte(8'h55); send_byte(8'hFF); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02);
        exp_q.push_back(16'hFF01);
        exp_q.push_back(16'h0002);
        send_byte(8'hFE);
        check_burst(2, "wrap");
    endtask

    task automatic test_max_len();
        // addr F8, 16 bytes 00..0F: csum = F8 ^ 10 ^ 00 = E8; addresses wrap.
        send_byte(8'h55); send_byte(8'hF8); send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            exp_q.push_back({8'(8'hF8 + i), 8'(i)});
        end
        send_byte(8'hE8);
        check_burst(16, "maxlen");
    endtask

    task automatic test_bad_csum();
        int w0;
        w0 = wr_cnt;
        send_byte(8'h55); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h8C);
        @(posedge clk); #1;
        n_vec++;
        if ({frame_err, err_code, busy, frame_ok} !== {1'b1, ERR_CSUM, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL csum_err: got err=%b code=%0d busy=%b ok=%b, required 1 1 1 0",
                     frame_err, err_code, busy, frame_ok);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if ({frame_err, err_code, busy} !== {1'b0, ERR_CSUM, 1'b0} || wr_cnt != w0) begin
            n_err++;
            $display("FAIL csum_after: got err=%b code=%0d busy=%b writes=%0d, required 0 1 0 0",
                     frame_err, err_code, busy, wr_cnt - w0);
        end
        test_good_frame();
    endtask

    task automatic test_len_err(input logic [7:0] len_byte);
        send_byte(8'h55); send_byte(8'h10); send_byte(len_byte);
        @(posedge clk); #1;
        n_vec++;
        if ({frame_err, err_code, busy} !== {1'b1, ERR_LEN, 1'b1}) begin
            n_err++;
            $display("FAIL len_err %h: got err=%b code=%0d busy=%b, required 1 2 1",
                     len_byte, frame_err, err_code, busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({frame_err, busy, wr_en} !== 3'b000 || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL len_idle %h: got err=%b busy=%b en=%b st=%0d, required 000 IDLE",
                     len_byte, frame_err, busy, wr_en, dbg_state);
        end
    endtask

    task automatic test_timeout();
        int seen;
        int w0;
        seen = -1;
        w0   = wr_cnt;
        send_byte(8'h55); send_byte(8'h10); send_byte(8'h02); send_byte(8'hA5);
        for (int k = 1; k <= TIMEOUT + 3; k++) begin
            @(posedge clk); #1;
            if (frame_err === 1'b1 && seen < 0) begin
                seen = k;
                n_vec++;
                if (err_code !== ERR_TMO) begin
                    n_err++;
                    $display("FAIL tmo_code: got %0d, required 3", err_code);
                end
            end
        end
        n_vec++;
        if (seen != TIMEOUT) begin
            n_err++;
            $display("FAIL tmo_cycle: got %0d, required %0d", seen, TIMEOUT);
        end
        send_byte(8'h3C);
        repeat (4) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if ({busy, frame_err} !== 2'b00 || dbg_state !== IDLE || wr_cnt != w0) begin
            n_err++;
            $display("FAIL tmo_after: got busy=%b err=%b st=%0d writes=%0d, required 0 0 IDLE 0",
                     busy, frame_err, dbg_state, wr_cnt - w0);
        end
    endtask

    task automatic test_garbage();
        logic [7:0] g [3];
        int w0;
        g[0] = 8'h00; g[1] = 8'hFF; g[2] = 8'hAA;
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(g[i]);
            @(posedge clk); #1;
            n_vec++;
            if ({busy, frame_err, frame_ok, wr_en} !== 4'b0000 || dbg_state !== IDLE) begin
                n_err++;
                $display("FAIL garbage %h: got busy=%b err=%b ok=%b en=%b st=%0d, required 0000 IDLE",
                         g[i], busy, frame_err, frame_ok, wr_en, dbg_state);
            end
        end
        n_vec++;
        if (wr_cnt != w0) begin
            n_err++;
            $display("FAIL garbage_writes: got %0d, required 0", wr_cnt - w0);
        end
    endtask

    task automatic test_reset_burst();
        int w0;
        // addr 20, 8 bytes 01..08: csum = 20 ^ 08 ^ 08 = 20.
        send_byte(8'h55); send_byte(8'h20); send_byte(8'h08);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h20);
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h22, 8'h03}) begin
            n_err++;
            $display("FAIL rst_pre: got en=%b %h/%h, required 1 22/03", wr_en, wr_addr, wr_data);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy} !== 22'd0 ||
            dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL rst_mid: got en=%b a=%h d=%h ok=%b err=%b code=%0d busy=%b, required all 0",
                     wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy);
        end
        w0 = wr_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (wr_cnt != w0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_after: got writes=%0d busy=%b, required 0 0", wr_cnt - w0, busy);
        end
        test_good_frame();
    endtask

    // ---------------- sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        test_good_frame();
        test_addr_wrap();
        test_max_len();
        test_bad_csum();
        test_len_err(8'h00);
        test_len_err(8'h11);
        test_timeout();
        test_garbage();
        test_reset_burst();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: got %0d unconsumed writes, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
